// File: rtl/gbrom_pkg.sv
// Shared constants and state encoding for the Game Boy ROM shadow loader.
package gbrom_pkg;

  localparam logic [7:0] CMD_RELEASE_PD = 8'hAB;
  localparam logic [7:0] CMD_READ       = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    WAKE_CMD,
    WAKE_GAP,
    READ_CMD,
    READ_DATA,
    DONE
  } gbrom_state_t;

  // Odd byte offsets live in the upper half of a 16-bit RAM word.
  function automatic logic [3:0] byte_mask(input logic odd);
    return odd ? 4'b1100 : 4'b0011;
  endfunction

endpackage

// File: rtl/spram_16k16.sv
// 16K x 16 single-port RAM with nibble write masks and one-cycle read latency.
// Maps onto SB_SPRAM256KA for iCE40UP builds; otherwise a behavioural array.
module spram_16k16 (
  input  logic        clk,
  input  logic [13:0] addr,
  input  logic [15:0] din,
  input  logic [3:0]  maskwren,
  input  logic        wren,
  output logic [15:0] dout
);

`ifdef ICE40_SPRAM
  SB_SPRAM256KA u_spram (
    .ADDRESS    (addr),
    .DATAIN     (din),
    .MASKWREN   (maskwren),
    .WREN       (wren),
    .CHIPSELECT (1'b1),
    .CLOCK      (clk),
    .STANDBY    (1'b0),
    .SLEEP      (1'b0),
    .POWEROFF   (1'b1),
    .DATAOUT    (dout)
  );
`else
  logic [15:0] mem [0:16383];

  always_ff @(posedge clk) begin
    if (wren) begin
      for (int n = 0; n < 4; n++) begin
        if (maskwren[n]) mem[addr][n*4 +: 4] <= din[n*4 +: 4];
      end
    end
    dout <= mem[addr];
  end
`endif

endmodule

// File: rtl/spram_gbrom.sv
// Boot-time ROM shadow: copies a ROM image from SPI flash into SPRAM after reset,
// then serves registered byte reads to the cartridge bus.
module spram_gbrom
  import gbrom_pkg::*;
#(
  parameter logic [23:0] FLASH_ADDR  = 24'h100000,
  parameter int          ROM_BYTES   = 32768,
  parameter int          WAKE_CYCLES = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] addr,
  output logic [7:0]  read_data,
  output logic        rom_loaded,
  output logic        spi_sck,
  output logic        spi_ssn,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [15:0] ROM_COUNT = 16'(ROM_BYTES);
  localparam logic [15:0] GAP_LAST  = 16'(WAKE_CYCLES - 1);

  gbrom_state_t state_q, state_d;
  logic         sck_q, sck_d;
  logic         ssn_q, ssn_d;
  logic [31:0]  shift_q, shift_d;
  logic [5:0]   bit_cnt_q, bit_cnt_d;
  logic [6:0]   rx_q, rx_d;
  logic [15:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0]  gap_cnt_q, gap_cnt_d;
  logic         wr_en_q, wr_en_d;
  logic [14:0]  wr_off_q, wr_off_d;
  logic [7:0]   wr_byte_q, wr_byte_d;

  logic [5:0]   frame_bits;
  logic         loaded;

  assign frame_bits = (state_q == WAKE_CMD) ? 6'd8 : 6'd32;
  assign loaded     = (state_q == DONE);

  // Every transfer state advances one SPI half-period per clk: a low sck phase
  // rises (sampling miso), a high phase falls (presenting the next mosi bit).
  always_comb begin
    state_d    = state_q;
    sck_d      = sck_q;
    ssn_d      = ssn_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    wr_en_d    = 1'b0;
    wr_off_d   = wr_off_q;
    wr_byte_d  = wr_byte_q;

    case (state_q)
      IDLE: begin
        state_d   = WAKE_CMD;
        ssn_d     = 1'b0;
        shift_d   = {CMD_RELEASE_PD, 24'h000000};
        bit_cnt_d = '0;
      end

      WAKE_CMD, READ_CMD: begin
        if (!sck_q) begin
          sck_d     = 1'b1;
          bit_cnt_d = bit_cnt_q + 6'd1;
        end else begin
          sck_d = 1'b0;
          if (bit_cnt_q == frame_bits) begin
            shift_d   = '0;
            bit_cnt_d = '0;
            if (state_q == WAKE_CMD) begin
              ssn_d     = 1'b1;
              gap_cnt_d = '0;
              state_d   = WAKE_GAP;
            end else begin
              byte_cnt_d = '0;
              state_d    = READ_DATA;
            end
          end else begin
            shift_d = {shift_q[30:0], 1'b0};
          end
        end
      end

      WAKE_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = READ_CMD;
          ssn_d     = 1'b0;
          shift_d   = {CMD_READ, FLASH_ADDR};
          bit_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end

      READ_DATA: begin
        if (!sck_q) begin
          sck_d     = 1'b1;
          rx_d      = {rx_q[5:0], spi_miso};
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd7) begin
            wr_en_d    = 1'b1;
            wr_byte_d  = {rx_q, spi_miso};
            wr_off_d   = byte_cnt_q[14:0];
            byte_cnt_d = byte_cnt_q + 16'd1;
            bit_cnt_d  = '0;
          end
        end else begin
          sck_d = 1'b0;
          // The final byte's RAM write lands on the same edge that enters DONE.
          if (byte_cnt_q == ROM_COUNT) begin
            ssn_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        sck_d = 1'b0;
        ssn_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sck_q      <= 1'b0;
      ssn_q      <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_off_q   <= '0;
      wr_byte_q  <= '0;
    end else begin
      state_q    <= state_d;
      sck_q      <= sck_d;
      ssn_q      <= ssn_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_off_q   <= wr_off_d;
      wr_byte_q  <= wr_byte_d;
    end
  end

  assign spi_sck    = sck_q;
  assign spi_ssn    = ssn_q;
  assign spi_mosi   = shift_q[31];
  assign rom_loaded = loaded;

  logic [13:0] ram_addr;
  logic [15:0] ram_din;
  logic [3:0]  ram_mask;
  logic        ram_wren;
  logic [15:0] ram_dout;

  // The loader owns the RAM port until the image is complete.
  assign ram_addr = loaded ? addr[14:1] : wr_off_q[14:1];
  assign ram_din  = {wr_byte_q, wr_byte_q};
  assign ram_mask = byte_mask(wr_off_q[0]);
  assign ram_wren = wr_en_q & ~loaded;

  spram_16k16 u_ram (
    .clk      (clk),
    .addr     (ram_addr),
    .din      (ram_din),
    .maskwren (ram_mask),
    .wren     (ram_wren),
    .dout     (ram_dout)
  );

  logic       rd_sel_q;
  logic       rd_valid_q;
  logic [7:0] read_data_q;

  // rd_valid_q lags rom_loaded so the first RAM word presented is a bus read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      read_data_q <= 8'h00;
    end else begin
      rd_sel_q    <= addr[0];
      rd_valid_q  <= loaded;
      read_data_q <= rd_valid_q ? (rd_sel_q ? ram_dout[15:8] : ram_dout[7:0]) : 8'h00;
    end
  end

  assign read_data = read_data_q;

endmodule

// File: tb/tb_spram_gbrom.sv
// Bench for spram_gbrom: behavioural SPI flash, protocol monitor and a read scoreboard.
module tb_spram_gbrom;

  localparam int          ROM_BYTES   = 1024;
  localparam int          WAKE_CYCLES = 48;
  localparam logic [23:0] FLASH_ADDR  = 24'h100000;
  localparam int          CLK_PERIOD  = 10;
  localparam int          LOAD_BUDGET = 2 * (40 + ROM_BYTES * 8) + WAKE_CYCLES + 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] addr = '0;
  logic [7:0]  read_data;
  logic        rom_loaded;
  logic        spi_sck;
  logic        spi_ssn;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  int checks = 0;
  int failures = 0;

  spram_gbrom #(
    .FLASH_ADDR  (FLASH_ADDR),
    .ROM_BYTES   (ROM_BYTES),
    .WAKE_CYCLES (WAKE_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .read_data  (read_data),
    .rom_loaded (rom_loaded),
    .spi_sck    (spi_sck),
    .spi_ssn    (spi_ssn),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  // ---------------- clock ----------------
  always #(CLK_PERIOD / 2) clk = ~clk;

  initial begin
    #(CLK_PERIOD * 90000);
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int off);
    return 8'((off & 255) ^ (off >> 8));
  endfunction

  // ---------------- SPI flash model ----------------
  int         miso_mode = 0;
  int         edge_cnt = 0;
  int         last_len = 0;
  int         total_rises = 0;
  int         stray_edges = 0;
  logic [7:0] mosi_sh = '0;
  logic [7:0] cmd_q[$];
  int         frame_len_q[$];
  int         gap_q[$];
  time        rise_t = 0;

  always @(posedge spi_sck) begin
    total_rises++;
    if (spi_ssn !== 1'b0) begin
      stray_edges++;
    end else begin
      mosi_sh = {mosi_sh[6:0], spi_mosi};
      edge_cnt++;
      if (edge_cnt <= 32 && (edge_cnt % 8) == 0) cmd_q.push_back(mosi_sh);
    end
  end

  // Flash shifts its next data bit out on the falling sck edge.
  always @(negedge spi_sck) begin
    int         k;
    logic [7:0] b;
    if (spi_ssn === 1'b0 && edge_cnt >= 32) begin
      k = edge_cnt - 32;
      b = (miso_mode != 0) ? pat(k / 8) : 8'h00;
      spi_miso = b[7 - (k % 8)];
    end else begin
      spi_miso = 1'b0;
    end
  end

  always @(posedge spi_ssn) begin
    last_len = edge_cnt;
    rise_t = $time;
    if (edge_cnt > 0) frame_len_q.push_back(edge_cnt);
  end

  always @(negedge spi_ssn) begin
    if (last_len == 8) gap_q.push_back(int'(($time - rise_t) / CLK_PERIOD));
    edge_cnt = 0;
  end

  // ---------------- protocol monitor ----------------
  int   mosi_viol = 0;
  int   sck_ssn_viol = 0;
  logic sck_prev = 1'b0;
  logic mosi_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (sck_prev === 1'b1 && spi_sck === 1'b1 && spi_mosi !== mosi_prev) mosi_viol++;
    if (spi_ssn === 1'b1 && spi_sck === 1'b1) sck_ssn_viol++;
    sck_prev = spi_sck;
    mosi_prev = spi_mosi;
  end

  // ---------------- read scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp_img [0:ROM_BYTES-1];
  logic       rd_issue = 1'b0;
  logic       rd_v1 = 1'b0;
  logic       rd_v2 = 1'b0;

  // Data for an address presented before edge N is due after edge N+1.
  always @(posedge clk) begin
    rd_v1 <= rd_issue;
    rd_v2 <= rd_v1;
  end

  always @(negedge clk) begin
    if (rd_v2) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got 0x%0h, expected no read", read_data);
      end else begin
        check("rd_data", {24'h0, read_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_read(input logic [14:0] a);
    @(negedge clk);
    addr = a;
    rd_issue = 1'b1;
    exp_q.push_back(exp_img[a]);
  endtask

  task automatic drain_reads();
    @(negedge clk);
    rd_issue = 1'b0;
    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic clear_model();
    cmd_q.delete();
    frame_len_q.delete();
    gap_q.delete();
    edge_cnt = 0;
    last_len = 0;
  endtask

  task automatic wait_loaded(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < LOAD_BUDGET; i++) begin
      @(negedge clk);
      if (rom_loaded === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_frames();
    logic [7:0] exp_cmd [5];
    exp_cmd[0] = 8'hAB;
    exp_cmd[1] = 8'h03;
    exp_cmd[2] = FLASH_ADDR[23:16];
    exp_cmd[3] = FLASH_ADDR[15:8];
    exp_cmd[4] = FLASH_ADDR[7:0];
    check("cmd_byte_count", cmd_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < cmd_q.size()) check($sformatf("cmd_byte%0d", i), {24'h0, cmd_q[i]}, {24'h0, exp_cmd[i]});
    end
    check("frame_count", frame_len_q.size(), 2);
    if (frame_len_q.size() >= 2) begin
      check("wake_frame_edges", frame_len_q[0], 8);
      check("read_frame_edges", frame_len_q[1], 32 + ROM_BYTES * 8);
    end
    check("wake_gap_count", gap_q.size(), 1);
    if (gap_q.size() >= 1) check("wake_gap_long_enough", (gap_q[0] >= WAKE_CYCLES), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int idle_bad;
    int rises_before;

    // Reset hold: everything idle, no sck activity.
    idle_bad = 0;
    rises_before = total_rises;
    repeat (120) begin
      @(negedge clk);
      if (spi_ssn !== 1'b1 || spi_sck !== 1'b0 || spi_mosi !== 1'b0 ||
          rom_loaded !== 1'b0 || read_data !== 8'h00) idle_bad++;
    end
    check("reset_idle_cycles_bad", idle_bad, 0);
    check("reset_no_sck_edges", total_rises - rises_before, 0);
    check("reset_rom_loaded", rom_loaded, 0);
    check("reset_read_data", {24'h0, read_data}, 0);

    // Load 1: flash returns all zeros.
    miso_mode = 0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    addr = 15'($urandom_range(0, ROM_BYTES - 1));
    @(negedge clk);
    check("loading_rom_loaded_low", rom_loaded, 0);
    check("loading_read_data_zero", {24'h0, read_data}, 0);
    wait_loaded(ok);
    check("zero_load_done", ok, 1);
    repeat (4) @(negedge clk);
    check_frames();
    for (int i = 0; i < ROM_BYTES; i++) exp_img[i] = 8'h00;
    for (int i = 0; i < 20; i++) issue_read(15'($urandom_range(0, ROM_BYTES - 1)));
    drain_reads();

    // Load 2: pattern flash, aborted by reset half-way through the data phase.
    rst_n = 1'b0;
    miso_mode = 1;
    repeat (5) @(negedge clk);
    clear_model();
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < LOAD_BUDGET; i++) begin
      @(posedge clk);
      if (edge_cnt >= 32 + ROM_BYTES * 4) begin
        ok = 1'b1;
        break;
      end
    end
    check("reached_half_load", ok, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ssn_idle", spi_ssn, 1);
    check("abort_sck_idle", spi_sck, 0);
    check("abort_rom_loaded", rom_loaded, 0);
    repeat (20) @(negedge clk);
    check("abort_hold_rom_loaded", rom_loaded, 0);
    check("abort_hold_read_data", {24'h0, read_data}, 0);

    // Load 3: full restart with the pattern flash.
    clear_model();
    rst_n = 1'b1;
    wait_loaded(ok);
    check("pattern_load_done", ok, 1);
    repeat (4) @(negedge clk);
    check_frames();
    for (int i = 0; i < ROM_BYTES; i++) exp_img[i] = pat(i);
    check("model_byte_0x123", {24'h0, exp_img[15'h123]}, 32'h22);
    issue_read(15'h0000);
    issue_read(15'h0001);
    issue_read(15'h0123);
    issue_read(15'h03FF);
    issue_read(15'h0201);
    drain_reads();
    for (int i = 0; i < 16; i++) issue_read(15'(i));
    drain_reads();
    for (int i = 0; i < 40; i++) issue_read(15'($urandom_range(0, ROM_BYTES - 1)));
    drain_reads();
    check("rom_loaded_stays_high", rom_loaded, 1);

    check("mosi_changed_while_sck_high", mosi_viol, 0);
    check("sck_high_while_ssn_high", sck_ssn_viol, 0);
    check("sck_rise_while_ssn_high", stray_edges, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spram_gbrom.md
Name: spram_gbrom

Overview:
- Boot-time ROM shadow for the FPGA Game Boy cartridge.
- After reset, reads a 32 KiB Game Boy ROM image from external SPI flash into on-chip single-port RAM: iCE40UP SPRAM, 16K x 16.
- Then serves synchronous byte reads to the cartridge bus logic on a 15-bit address.
- rom_loaded tells the cartridge logic when the image is valid.

Parameters:
- FLASH_ADDR, 24'h100000, byte address in flash where the ROM image starts.
- ROM_BYTES, 32768, number of bytes copied. Must be even and at most 32768.
- WAKE_CYCLES, 48, clk cycles spi_ssn is held high after the release-power-down command (about 4 us at 12 MHz).

Ports:
- clk  in  1  system clock, about 12 MHz.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  15  ROM byte address from the cartridge bus.
- read_data  out  8  byte at the registered addr.
- rom_loaded  out  1  high once the full image has been copied; stays high until reset.
- spi_sck  out  1  SPI clock, mode 0.
- spi_ssn  out  1  flash chip select, active low.
- spi_mosi  out  1  SPI data to flash.
- spi_miso  in  1  SPI data from flash.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - spi_sck=0, spi_ssn=1, spi_mosi=0;
  - rom_loaded=0, read_data=8'h00;
  - FSM in IDLE, all counters cleared.
- SPI timing:
  - Mode 0, MSB first.
  - spi_sck = clk/2: it toggles every clk cycle while a transfer is active.
  - spi_mosi changes only while spi_sck is low.
  - spi_miso is sampled on the clk edge that drives spi_sck high.
  - spi_sck idles low whenever spi_ssn=1.
- FSM states and transitions:
  - IDLE → WAKE_CMD on the first clk after reset release.
  - WAKE_CMD: spi_ssn=0, shift out 8'hAB. Then spi_ssn=1 → WAKE_GAP.
  - WAKE_GAP: wait WAKE_CYCLES clks → READ_CMD.
  - READ_CMD: spi_ssn=0, shift out 8'h03, then FLASH_ADDR[23:0] MSB first (32 bits total) → READ_DATA.
  - READ_DATA: spi_ssn held low continuously while ROM_BYTES*8 bits are clocked in, with spi_mosi=0. Each completed byte is written to RAM at byte offset n (0..ROM_BYTES-1). After the last byte → DONE.
  - DONE: spi_ssn=1, spi_sck=0, rom_loaded=1 from the cycle after the last RAM write. Terminal until reset.
- Bus clock counts:
  - Exactly 8 spi_sck rising edges per command byte.
  - Exactly ROM_BYTES*8 rising edges during READ_DATA.
  - No extra edges while spi_ssn=1.
  - With miso constant, the total load takes about 2*(8 + 32 + 262144) + WAKE_CYCLES clks, roughly 44 ms at 12 MHz.
- RAM mapping:
  - Word address = byte_offset[14:1].
  - Even offsets write bits [7:0] with nibble mask 4'b0011.
  - Odd offsets write bits [15:8] with nibble mask 4'b1100.
- Read port:
  - Active only when rom_loaded=1. The loader owns the RAM until then, and read_data=8'h00 while rom_loaded=0.
  - After load, the RAM address is addr[14:1] every cycle, and addr[0] is registered alongside it.
  - read_data = registered addr[0] ? word[15:8] : word[7:0].
  - Latency: addr sampled at edge N, data valid after edge N+1. Back-to-back addresses give one result per cycle.
- Reset mid-load: the transfer aborts immediately (spi_ssn=1, spi_sck=0) and the whole sequence restarts from WAKE_CMD after release. Partial RAM contents are don't-care.
- addr changes during load are ignored.

Decomposition:
- Shared package gbrom_pkg:
  - CMD_RELEASE_PD=8'hAB, CMD_READ=8'h03;
  - the state enum (IDLE, WAKE_CMD, WAKE_GAP, READ_CMD, READ_DATA, DONE).
- One sub-module, spram_16k16:
  - wraps SB_SPRAM256KA: addr 14, din 16, maskwren 4, wren, dout 16;
  - provides a behavioural 16K x 16 model for simulation;
  - read latency 1 cycle.

Test Plan:
- Reset held 1 us → spi_ssn=1, spi_sck=0, rom_loaded=0, read_data=0 throughout, with no sck edges.
- Release reset, decode mosi on sck rising edges → first frame 0xAB (8 edges); spi_ssn high for at least WAKE_CYCLES clks; next frame 03 10 00 00.
- spi_miso tied 0 → rom_loaded rises before 50 ms with exactly 262144 sck rising edges in READ_DATA; afterwards any addr reads 8'h00.
- Flash model returns byte (offset & 8'hFF) ^ (offset>>8). After load:
  - addr 0x0000 → 0x00;
  - addr 0x0001 → 0x01;
  - addr 0x1234 → 0x26;
  - addr 0x7FFF → 0x80;
  - each value appears one cycle after addr.
- Streaming reads of addr 0..15 on consecutive cycles → 16 correct consecutive bytes with no bubbles.
- Assert rst_n=0 at half-way through READ_DATA → ssn and sck idle immediately and rom_loaded stays 0; after release the sequence restarts with 0xAB and completes with correct data.
